wb_rr_arb: RTL and testbench

Round-robin Wishbone bus arbiter for the shared-bus interconnect: it grants the single internal master bus to one of N_MASTERS requesters (master `cyc` lines). It preempts a long-running owner only at burst boundaries and runs a stall watchdog that terminates hung transfers with a bus error. It replaces the fixed-priority grant logic beside the address decoder; its one-hot `gnt` drives the interconnect's master mux and ack masking unchanged.

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 30 +++
 rtl/wb_rr_arb.sv | 118 +++++++++++
 tb/tb_wb_rr_arb.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ERR   = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Index width that stays at least one bit for tiny counts.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit after `last`, wrapping.
module rr_pick #(
  parameter int N  = 7,
  parameter int IW = 3
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [IW-1:0] j;

  // Scan from the far end back so the nearest candidate after `last` wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = N; i >= 1; i--) begin
      j = IW'((int'(last) + i) % N);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    onehot = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/wb_rr_arb.sv
// Round-robin Wishbone bus arbiter with burst-boundary preemption and stall watchdog.
module wb_rr_arb
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = 7,
  parameter int MAX_XFER  = 16,
  parameter int TIMEOUT   = 1024
)(
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [N_MASTERS-1:0]         req,
  input  logic                         bus_stb_i,
  input  logic [2:0]                   bus_cti_i,
  input  logic                         bus_ack_i,
  output logic [N_MASTERS-1:0]         gnt,
  output logic [$clog2(N_MASTERS)-1:0] gnt_idx,
  output logic                         busy,
  output logic [N_MASTERS-1:0]         m_err_o,
  output logic                         timeout_o
);

  localparam int IW = idx_w(N_MASTERS);
  localparam int XW = idx_w(MAX_XFER + 1);
  localparam int WW = idx_w(TIMEOUT);
  localparam logic [XW-1:0] XCAP = (MAX_XFER == 0) ? '0 : XW'(MAX_XFER - 1);
  localparam logic [WW-1:0] WCAP = WW'(TIMEOUT - 1);

  arb_state_e           st, st_nxt;
  logic [IW-1:0]        owner, last;
  logic [XW-1:0]        xfer_cnt;
  logic [WW-1:0]        wd_cnt;
  logic [N_MASTERS-1:0] pick_req, pick_oh;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic                 take, own_req, bnd_ack, preempt, expire;

  // While granted, the owner is masked so a release never re-grants it next cycle.
  assign pick_req = (st == GRANT) ? (req & ~gnt) : req;

  rr_pick #(.N(N_MASTERS), .IW(IW)) u_pick (
    .req    (pick_req),
    .last   (last),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  assign own_req = req[owner];
  assign bnd_ack = bus_ack_i && (bus_cti_i == CTI_CLASSIC || bus_cti_i == CTI_EOB);
  assign preempt = (MAX_XFER != 0) && bnd_ack && (xfer_cnt == XCAP) && pick_found;
  assign expire  = bus_stb_i && !bus_ack_i && (wd_cnt == WCAP);
  assign gnt_idx = owner;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) st <= IDLE;
    else            st <= st_nxt;
  end

  // Priority inside GRANT: owner drop, then preempt, then watchdog expiry.
  always_comb begin
    st_nxt = st;
    take   = 1'b0;
    unique case (st)
      IDLE: begin
        if (pick_found) begin
          take   = 1'b1;
          st_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!own_req) begin
          if (pick_found) take = 1'b1;
          else            st_nxt = IDLE;
        end else if (preempt) begin
          take = 1'b1;
        end else if (expire) begin
          st_nxt = ERR;
        end
      end
      ERR:     st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (st != IDLE);
    timeout_o = (st == ERR);
    m_err_o   = (st == ERR) ? gnt : '0;
  end

  // `last` already equals the owner, so an errored master ends up lowest priority.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt      <= '0;
      owner    <= '0;
      last     <= IW'(N_MASTERS - 1);
      xfer_cnt <= '0;
      wd_cnt   <= '0;
    end else begin
      if (take) begin
        gnt   <= pick_oh;
        owner <= pick_idx;
        last  <= pick_idx;
      end else if (st_nxt == IDLE) begin
        gnt <= '0;
      end
      if (take || st != GRANT) begin
        xfer_cnt <= '0;
        wd_cnt   <= '0;
      end else begin
        if (bnd_ack && xfer_cnt != XCAP) xfer_cnt <= xfer_cnt + 1'b1;
        if (!bus_stb_i || bus_ack_i)     wd_cnt   <= '0;
        else if (wd_cnt != WCAP)         wd_cnt   <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_rr_arb.sv
// Directed scoreboard bench for wb_rr_arb (7 masters, MAX_XFER=4, TIMEOUT=8).
module tb_wb_rr_arb;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [6:0] req;
  logic       bus_stb_i;
  logic [2:0] bus_cti_i;
  logic       bus_ack_i;
  logic [6:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic [6:0] m_err_o;
  logic       timeout_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [6:0] gnt;
    logic [6:0] err;
    logic       to;
  } exp_t;
  exp_t q[$];

  wb_rr_arb #(.N_MASTERS(7), .MAX_XFER(4), .TIMEOUT(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .bus_stb_i (bus_stb_i),
    .bus_cti_i (bus_cti_i),
    .bus_ack_i (bus_ack_i),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .busy      (busy),
    .m_err_o   (m_err_o),
    .timeout_o (timeout_o)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int oh2i(input logic [6:0] v);
    for (int i = 0; i < 7; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    e = q.pop_front();
    cmp({e.tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
    cmp({e.tag, "_err"}, 32'(m_err_o), 32'(e.err));
    cmp({e.tag, "_to"}, 32'(timeout_o), 32'(e.to));
    cmp({e.tag, "_busy"}, 32'(busy), 32'(|e.gnt));
    if (e.gnt != 7'd0) cmp({e.tag, "_idx"}, 32'(gnt_idx), 32'(oh2i(e.gnt)));
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge, check them.
  task automatic step(input string tag, input logic [6:0] r, input logic stb,
                      input logic [2:0] cti, input logic ack,
                      input logic [6:0] eg, input logic [6:0] ee, input logic et);
    exp_t e;
    req = r; bus_stb_i = stb; bus_cti_i = cti; bus_ack_i = ack;
    e.tag = tag; e.gnt = eg; e.err = ee; e.to = et;
    q.push_back(e);
    @(posedge sys_clk); #1;
    check_out();
  endtask

  task automatic do_reset();
    exp_t e;
    sys_rst_n = 1'b0; req = '0; bus_stb_i = 1'b0; bus_cti_i = 3'b000; bus_ack_i = 1'b0;
    @(posedge sys_clk); @(posedge sys_clk); #1;
    e.tag = "reset"; e.gnt = '0; e.err = '0; e.to = 1'b0;
    q.push_back(e);
    check_out();
    cmp("reset_idx", 32'(gnt_idx), 32'd0);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Basic grant and gapless handover
    step("g0",    7'b0000101, 0, 3'b000, 0, 7'b0000001, 0, 0);
    step("hold0", 7'b0000101, 0, 3'b000, 0, 7'b0000001, 0, 0);
    step("drop0", 7'b0000100, 0, 3'b000, 0, 7'b0000100, 0, 0);
    step("idle",  7'b0000000, 0, 3'b000, 0, 7'b0000000, 0, 0);

    // Full rotation, each owner releasing after one classic transfer
    do_reset();
    step("rr_start", 7'h7F, 0, 3'b000, 0, 7'h01, 0, 0);
    for (int k = 0; k < 7; k++) begin
      step($sformatf("rr_ack%0d", k), 7'h7F, 1, 3'b000, 1, 7'(1 << k), 0, 0);
      step($sformatf("rr_rel%0d", k), 7'h7F & ~7'(1 << k), 0, 3'b000, 0,
           7'(1 << ((k + 1) % 7)), 0, 0);
    end
    step("rr_end", 7'h00, 0, 3'b000, 0, 7'h00, 0, 0);

    // Preemption after MAX_XFER boundary acks
    step("pe_g1", 7'h02, 0, 3'b000, 0, 7'h02, 0, 0);
    for (int k = 1; k <= 3; k++)
      step($sformatf("pe_ack%0d", k), 7'h0A, 1, 3'b000, 1, 7'h02, 0, 0);
    step("pe_ack4", 7'h0A, 1, 3'b000, 1, 7'h08, 0, 0);
    step("pe_back", 7'h02, 0, 3'b000, 0, 7'h02, 0, 0);
    for (int k = 1; k <= 3; k++)
      step($sformatf("pb_ack%0d", k), 7'h0A, 1, 3'b000, 1, 7'h02, 0, 0);
    step("pb_incr", 7'h0A, 1, 3'b010, 1, 7'h02, 0, 0);
    step("pb_eob",  7'h0A, 1, 3'b111, 1, 7'h08, 0, 0);
    step("pb_idle", 7'h00, 0, 3'b000, 0, 7'h00, 0, 0);

    // Lone requester is never preempted; handover on first boundary ack after contention
    step("sat_g1", 7'h02, 0, 3'b000, 0, 7'h02, 0, 0);
    for (int k = 0; k < 6; k++)
      step($sformatf("sat_ack%0d", k), 7'h02, 1, 3'b000, 1, 7'h02, 0, 0);
    step("sat_wait", 7'h0A, 1, 3'b000, 0, 7'h02, 0, 0);
    step("sat_hand", 7'h0A, 1, 3'b000, 1, 7'h08, 0, 0);
    step("sat_idle", 7'h00, 0, 3'b000, 0, 7'h00, 0, 0);

    // Watchdog expiry on owner 2
    do_reset();
    step("wd_g2", 7'h04, 0, 3'b000, 0, 7'h04, 0, 0);
    for (int k = 0; k < 7; k++)
      step($sformatf("wd_stall%0d", k), 7'h24, 1, 3'b000, 0, 7'h04, 0, 0);
    step("wd_err",  7'h24, 1, 3'b000, 0, 7'h04, 7'h04, 1);
    step("wd_drop", 7'h24, 1, 3'b000, 0, 7'h00, 0, 0);
    step("wd_g5",   7'h24, 0, 3'b000, 0, 7'h20, 0, 0);

    // Ack in the expiry cycle wins and clears the watchdog
    for (int k = 0; k < 7; k++)
      step($sformatf("wa_stall%0d", k), 7'h24, 1, 3'b000, 0, 7'h20, 0, 0);
    step("wa_ack", 7'h24, 1, 3'b010, 1, 7'h20, 0, 0);
    for (int k = 0; k < 7; k++)
      step($sformatf("wa_again%0d", k), 7'h24, 1, 3'b000, 0, 7'h20, 0, 0);
    step("wa_err",  7'h24, 1, 3'b000, 0, 7'h20, 7'h20, 1);
    step("wa_drop", 7'h24, 0, 3'b000, 0, 7'h00, 0, 0);
    step("wa_g2",   7'h24, 0, 3'b000, 0, 7'h04, 0, 0);

    // Owner drop in the expiry cycle wins
    for (int k = 0; k < 7; k++)
      step($sformatf("wx_stall%0d", k), 7'h24, 1, 3'b000, 0, 7'h04, 0, 0);
    step("wx_drop", 7'h20, 1, 3'b000, 0, 7'h20, 0, 0);

    // Asynchronous reset mid-burst
    step("ar_burst", 7'h20, 1, 3'b010, 1, 7'h20, 0, 0);
    #2 sys_rst_n = 1'b0;
    #1;
    begin
      exp_t e;
      e.tag = "ar_async"; e.gnt = '0; e.err = '0; e.to = 1'b0;
      q.push_back(e);
      check_out();
    end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    step("ar_prio0", 7'h7F, 0, 3'b000, 0, 7'h01, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
